// File: rtl/nlp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nlp16_pkg
//  Purpose  : Shared types and constants for the NLP16 fetch/decode path.
//             Fetch FSM state encoding, IR extension bit position, PC width,
//             IR2 fill word and the wrapping PC increment helper.
//  Revision : 1.0 - initial release
// ============================================================================
package nlp16_pkg;

    localparam int              PC_W       = 16;
    localparam int              IR_EXT_BIT = 15;
    localparam logic [PC_W-1:0] NOP_WORD   = 16'h0000;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH1 = 4'd1,
        FETCH2 = 4'd2,
        HOLD   = 4'd3,
        ERR    = 4'd4
    } fetch_state_t;

    // Word-address increment; wraps 16'hFFFF -> 16'h0000 with no flag.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_watchdog
//  Purpose  : Counts consecutive cycles spent waiting for a memory ack and
//             flags expiry on the TIMEOUT-th waiting cycle.
//  Ports    : i_clk      clock
//             i_rst      asynchronous active-high reset
//             i_active   FSM is in a fetch state (counter runs)
//             i_clear    ack or redirect this cycle (counter restarts)
//             o_expired  TIMEOUT cycles elapsed without ack/redirect
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_clear,
    output logic o_expired
);

    localparam int                CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Count saturates at C_LAST; leaving the fetch states restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (!i_active || i_clear) begin
            r_count <= '0;
        end else if (r_count != C_LAST) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = i_active & ~i_clear & (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Fetches 16-bit words at PC, assembles one- or two-word
//             instructions (IR1 bit15 set => extension word in IR2) and hands
//             them to the decoder with valid/ready. Accepts branch redirects.
//  Ports    : i_clk, i_rst (async, active-high)
//             o_mem_addr/o_mem_rd/i_mem_rdata/i_mem_ack  memory read port
//             o_ir1/o_ir2/o_ir_valid/i_ir_ready/o_pc     decoder interface
//             i_redirect/i_redirect_pc                   PC redirect
//             o_state (debug), o_err (sticky timeout error)
//  Config   : IFETCH_TIMEOUT_EN - enables the ack watchdog and ERR state.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import nlp16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [15:0] o_ir1,
    output logic [15:0] o_ir2,
    output logic        o_ir_valid,
    input  logic        i_ir_ready,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic [15:0] o_pc,
    output logic [3:0]  o_state,
    output logic        o_err
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_mem_addr;
    logic [PC_W-1:0] r_ir1;
    logic [PC_W-1:0] r_ir2;
    logic [PC_W-1:0] r_out_pc;
    logic            r_mem_rd;
    logic            r_ir_valid;
    logic            r_err;

    logic            w_ack;
    logic            w_timeout;
    logic [PC_W-1:0] w_pc_next;

    // An ack only counts against a request that is actually outstanding.
    assign w_ack     = i_mem_ack & r_mem_rd;
    assign w_pc_next = pc_inc(r_pc);

`ifdef IFETCH_TIMEOUT_EN
    logic w_wd_active;
    assign w_wd_active = (r_state == FETCH1) || (r_state == FETCH2);

    ifetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_active  (w_wd_active),
        .i_clear   (w_ack | i_redirect),
        .o_expired (w_timeout)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_rd   <= 1'b0;
            r_ir1      <= NOP_WORD;
            r_ir2      <= NOP_WORD;
            r_ir_valid <= 1'b0;
            r_out_pc   <= RESET_PC;
            r_err      <= 1'b0;
        end else if (i_redirect && (r_state != ERR)) begin
            // Cancel any outstanding read; FETCH1 re-issues it next cycle.
            r_pc       <= i_redirect_pc;
            r_mem_addr <= i_redirect_pc;
            r_mem_rd   <= 1'b0;
            r_ir_valid <= 1'b0;
            r_state    <= FETCH1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_addr <= r_pc;
                    r_mem_rd   <= 1'b1;
                    r_state    <= FETCH1;
                end
                FETCH1: begin
                    if (w_timeout) begin
                        r_mem_rd <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= ERR;
                    end else if (!r_mem_rd) begin
                        // First cycle after a redirect: raise the request.
                        r_mem_addr <= r_pc;
                        r_mem_rd   <= 1'b1;
                    end else if (w_ack) begin
                        r_ir1      <= i_mem_rdata;
                        r_out_pc   <= r_pc;
                        r_pc       <= w_pc_next;
                        r_mem_addr <= w_pc_next;
                        if (i_mem_rdata[IR_EXT_BIT]) begin
                            r_state <= FETCH2;
                        end else begin
                            r_ir2      <= NOP_WORD;
                            r_mem_rd   <= 1'b0;
                            r_ir_valid <= 1'b1;
                            r_state    <= HOLD;
                        end
                    end
                end
                FETCH2: begin
                    if (w_timeout) begin
                        r_mem_rd <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= ERR;
                    end else if (w_ack) begin
                        r_ir2      <= i_mem_rdata;
                        r_pc       <= w_pc_next;
                        r_mem_addr <= w_pc_next;
                        r_mem_rd   <= 1'b0;
                        r_ir_valid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_ir_ready) begin
                        r_ir_valid <= 1'b0;
                        r_mem_addr <= r_pc;
                        r_mem_rd   <= 1'b1;
                        r_state    <= FETCH1;
                    end
                end
                ERR: begin
                    r_mem_rd   <= 1'b0;
                    r_ir_valid <= 1'b0;
                end
                default: begin
                    r_mem_rd   <= 1'b0;
                    r_ir_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_addr = r_mem_addr;
    assign o_mem_rd   = r_mem_rd;
    assign o_ir1      = r_ir1;
    assign o_ir2      = r_ir2;
    assign o_ir_valid = r_ir_valid;
    assign o_pc       = r_out_pc;
    assign o_state    = r_state;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Self-checking bench for instruction_fetch. A memory model acks
//             every request one cycle after it appears; expected instructions
//             are queued by the stimulus and checked by a monitor on accept.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic [15:0] i_mem_rdata;
    logic        i_mem_ack;
    logic [15:0] o_ir1;
    logic [15:0] o_ir2;
    logic        o_ir_valid;
    logic        i_ir_ready;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic [15:0] o_pc;
    logic [3:0]  o_state;
    logic        o_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] ir1;
        logic [15:0] ir2;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem [logic [15:0]];
    logic        ack_en;

    instruction_fetch #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_mem_addr    (o_mem_addr),
        .o_mem_rd      (o_mem_rd),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_ack     (i_mem_ack),
        .o_ir1         (o_ir1),
        .o_ir2         (o_ir2),
        .o_ir_valid    (o_ir_valid),
        .i_ir_ready    (i_ir_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_pc          (o_pc),
        .o_state       (o_state),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    // Memory: acks a request presented at the previous edge.
    always @(posedge clk) begin
        #1;
        if (ack_en && o_mem_rd && !rst) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = mem_read(o_mem_addr);
        end else begin
            i_mem_ack   = 1'b0;
            i_mem_rdata = 16'hDEAD;
        end
    end

    // Monitor: every accepted instruction must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_ir_valid && i_ir_ready && !i_redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL accept_unexpected: got ir1=%h ir2=%h pc=%h, required no instruction",
                         o_ir1, o_ir2, o_pc);
            end else begin
                e = exp_q.pop_front();
                if ({o_ir1, o_ir2, o_pc} !== e) begin
                    failures++;
                    $display("FAIL accept_instr: got ir1=%h ir2=%h pc=%h, required ir1=%h ir2=%h pc=%h",
                             o_ir1, o_ir2, o_pc, e.ir1, e.ir2, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_ir_valid && n < 20) begin
            tick();
            n++;
        end
        if (!o_ir_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: got o_ir_valid=0 after 20 cycles, required 1", name);
        end
    endtask

    task automatic accept();
        i_ir_ready = 1'b1;
        tick();
        i_ir_ready = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] target);
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        tick();
        i_redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst           = 1'b1;
        ack_en        = 1'b1;
        i_ir_ready    = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 16'h0000;
        i_mem_ack     = 1'b0;
        i_mem_rdata   = 16'h0000;
        mem[16'h0000] = 16'h2000;
        mem[16'h0001] = 16'hB01D;
        mem[16'h0002] = 16'h5600;
        mem[16'h0003] = 16'h1234;
        mem[16'h0040] = 16'h7777;
        mem[16'h0050] = 16'h1111;
        mem[16'hFFFF] = 16'h0ABC;

        tick(); tick(); tick();
        // {state, rd, valid, err}, addr, ir1, ir2, pc after reset
        check("reset_ctrl", {60'd0, o_state[0], o_mem_rd, o_ir_valid, o_err}, 64'd0);
        check("reset_state", {60'd0, o_state}, 64'd0);
        check("reset_data", {o_mem_addr, o_ir1, o_ir2, o_pc}, 64'd0);

        exp_q.push_back('{ir1: 16'h2000, ir2: 16'h0000, pc: 16'h0000});
        exp_q.push_back('{ir1: 16'hB01D, ir2: 16'h5600, pc: 16'h0001});
        exp_q.push_back('{ir1: 16'h1234, ir2: 16'h0000, pc: 16'h0003});
        rst = 1'b0;

        // One-word instruction at 0
        wait_valid("valid_one_word");
        accept();
        check("after_one_word", {47'd0, o_ir_valid, o_mem_rd, o_mem_addr}, {47'd0, 1'b0, 1'b1, 16'h0001});

        // Two-word instruction at 1/2
        wait_valid("valid_two_word");
        accept();
        check("after_two_word", {47'd0, o_ir_valid, o_mem_rd, o_mem_addr}, {47'd0, 1'b0, 1'b1, 16'h0003});

        // Decoder stalls 5 cycles on the instruction at 3
        wait_valid("valid_stall");
        for (int i = 0; i < 5; i++) begin
            check("hold_stable", {o_ir1, o_ir2, o_pc, 14'd0, o_ir_valid, o_mem_rd},
                  {16'h1234, 16'h0000, 16'h0003, 14'd0, 1'b1, 1'b0});
            tick();
        end
        accept();
        check("after_stall", {47'd0, o_ir_valid, o_mem_rd, o_mem_addr}, {47'd0, 1'b0, 1'b1, 16'h0004});

        // One-word instruction at FFFF: PC wraps to 0000
        exp_q.push_back('{ir1: 16'h0ABC, ir2: 16'h0000, pc: 16'hFFFF});
        redirect(16'hFFFF);
        check("redirect_ffff", {43'd0, o_ir_valid, o_state, o_mem_rd, o_mem_addr},
              {43'd0, 1'b0, 4'd1, 1'b0, 16'hFFFF});
        wait_valid("valid_wrap1");
        accept();
        check("wrap_one_word", {47'd0, o_ir_valid, o_mem_rd, o_mem_addr}, {47'd0, 1'b0, 1'b1, 16'h0000});

        // Two-word instruction at FFFF: extension comes from 0000
        mem[16'hFFFF] = 16'h8ABC;
        exp_q.push_back('{ir1: 16'h8ABC, ir2: 16'h2000, pc: 16'hFFFF});
        redirect(16'hFFFF);
        wait_valid("valid_wrap2");
        accept();
        check("wrap_two_word", {47'd0, o_ir_valid, o_mem_rd, o_mem_addr}, {47'd0, 1'b0, 1'b1, 16'h0001});

        // Redirect in FETCH2 in the same cycle as the ack
        tick();
        check("in_fetch2", {60'd0, o_state}, 64'd2);
        redirect(16'h0040);
        check("redirect_fetch2", {43'd0, o_ir_valid, o_state, o_mem_rd, o_mem_addr},
              {43'd0, 1'b0, 4'd1, 1'b0, 16'h0040});
        tick();
        check("refetch_0040", {47'd0, o_ir_valid, o_mem_rd, o_mem_addr}, {47'd0, 1'b0, 1'b1, 16'h0040});

        // Redirect while valid&ready: held instruction is dropped
        wait_valid("valid_0040");
        check("held_0040", {16'd0, o_ir1, o_ir2, o_pc}, {16'd0, 16'h7777, 16'h0000, 16'h0040});
        i_ir_ready = 1'b1;
        redirect(16'h0050);
        i_ir_ready = 1'b0;
        check("drop_redirect", {43'd0, o_ir_valid, o_state, o_mem_rd, o_mem_addr},
              {43'd0, 1'b0, 4'd1, 1'b0, 16'h0050});
        exp_q.push_back('{ir1: 16'h1111, ir2: 16'h0000, pc: 16'h0050});
        wait_valid("valid_0050");
        accept();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // Async reset mid-fetch drops the request immediately
        tick();
        rst = 1'b1;
        #1;
        check("async_reset", {59'd0, o_state, o_mem_rd}, 64'd0);
        ack_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("waiting_16", {58'd0, o_state, o_err, o_mem_rd}, {58'd0, 4'd1, 1'b0, 1'b1});
        tick();
`ifdef IFETCH_TIMEOUT_EN
        check("timeout_err", {57'd0, o_state, o_err, o_mem_rd, o_ir_valid}, {57'd0, 4'd4, 1'b1, 1'b0, 1'b0});
`else
        check("no_timeout", {57'd0, o_state, o_err, o_mem_rd, o_ir_valid}, {57'd0, 4'd1, 1'b0, 1'b1, 1'b0});
`endif
        #2;
        rst = 1'b1;
        #1;
        check("reset_clears_err", {59'd0, o_state, o_err}, 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
